// File: rtl/hazard_flush_controller_if.sv
// Pipeline-side signal bundle for the hazard/flush controller.
// The controller takes the slave modport; the pipeline (or bench) takes master.
interface hazard_flush_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_UsesRs;
  logic             ID_UsesRt;
  logic             ID_Jump;
  logic [4:0]       EX_Rs;
  logic [4:0]       EX_Rt;
  logic             EX_MemRead;
  logic [4:0]       EX_WriteReg;
  logic             EX_Jr;
  logic             M_RegWrite;
  logic [4:0]       M_WriteReg;
  logic             M_PCSrc;
  logic             WB_RegWrite;
  logic [4:0]       WB_WriteReg;
  logic             PCWrite;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Flush;
  logic             EXMEM_Flush;
  logic [1:0]       ForwardA;
  logic [1:0]       ForwardB;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_Jump,
    input  EX_Rs, EX_Rt, EX_MemRead, EX_WriteReg, EX_Jr,
    input  M_RegWrite, M_WriteReg, M_PCSrc, WB_RegWrite, WB_WriteReg,
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush,
    output ForwardA, ForwardB, StallCount, FlushCount
  );

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_Jump,
    output EX_Rs, EX_Rt, EX_MemRead, EX_WriteReg, EX_Jr,
    output M_RegWrite, M_WriteReg, M_PCSrc, WB_RegWrite, WB_WriteReg,
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush,
    input  ForwardA, ForwardB, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_flush_controller.sv
// Load-use stall, control-flow flush and EX forwarding control for the
// 5-stage MIPS pipeline, with saturating stall/flush event counters.
module hazard_flush_controller #(
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                        Clk,
  input  logic                        Reset,
  hazard_flush_controller_if.slave    bus
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [3:0] RELOAD = 4'(LOAD_USE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             lu;
  logic             pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_count, flush_count;

  assign lu = bus.EX_MemRead && (bus.EX_WriteReg != 5'd0) &&
              ((bus.ID_UsesRs && (bus.ID_Rs == bus.EX_WriteReg)) ||
               (bus.ID_UsesRt && (bus.ID_Rt == bus.EX_WriteReg)));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (Reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_nxt   = RUN;
      cnt_nxt     = '0;
    end else if (bus.M_PCSrc) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_nxt   = RUN;
      cnt_nxt     = '0;
    end else if (bus.EX_Jr) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      state_nxt   = RUN;
      cnt_nxt     = '0;
    end else if ((state == STALL) || lu) begin
      // A pending ID_Jump is deliberately dropped here; ID holds it and it re-decodes after the stall.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      if (state == RUN) begin
        if (LOAD_USE_CYCLES > 1) begin
          state_nxt = STALL;
          cnt_nxt   = RELOAD;
        end
      end else if (cnt == 4'd1) begin
        if (lu) begin
          cnt_nxt = RELOAD;
        end else begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end else begin
        cnt_nxt = cnt - 4'd1;
      end
    end else if (bus.ID_Jump) begin
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!Reset) begin
      if (bus.M_RegWrite && (bus.M_WriteReg != 5'd0) && (bus.M_WriteReg == bus.EX_Rs))
        fwd_a = 2'b10;
      else if (bus.WB_RegWrite && (bus.WB_WriteReg != 5'd0) && (bus.WB_WriteReg == bus.EX_Rs))
        fwd_a = 2'b01;
      if (bus.M_RegWrite && (bus.M_WriteReg != 5'd0) && (bus.M_WriteReg == bus.EX_Rt))
        fwd_b = 2'b10;
      else if (bus.WB_RegWrite && (bus.WB_WriteReg != 5'd0) && (bus.WB_WriteReg == bus.EX_Rt))
        fwd_b = 2'b01;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_write && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if ((ifid_flush || idex_flush || exmem_flush) && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end

  assign bus.PCWrite     = pc_write;
  assign bus.IFID_Write  = ifid_write;
  assign bus.IFID_Flush  = ifid_flush;
  assign bus.IDEX_Flush  = idex_flush;
  assign bus.EXMEM_Flush = exmem_flush;
  assign bus.ForwardA    = fwd_a;
  assign bus.ForwardB    = fwd_b;
  assign bus.StallCount  = stall_count;
  assign bus.FlushCount  = flush_count;

endmodule

// File: tb/tb_hazard_flush_controller.sv
// Directed checks of hazard_flush_controller: instance a (1 bubble, 4-bit
// counters for saturation) and instance b (3 bubbles, 32-bit counters).
module tb_hazard_flush_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wr, m_wr, wb_wr;
  logic       id_uses_rs, id_uses_rt, id_jump, ex_memread, ex_jr;
  logic       m_regwrite, m_pcsrc, wb_regwrite;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_flush_controller_if #(.CNT_W(4))  a_if ();
  hazard_flush_controller_if #(.CNT_W(32)) b_if ();

  hazard_flush_controller #(.LOAD_USE_CYCLES(1), .CNT_W(4)) dut_a (
    .Clk(clk), .Reset(rst), .bus(a_if.slave)
  );
  hazard_flush_controller #(.LOAD_USE_CYCLES(3), .CNT_W(32)) dut_b (
    .Clk(clk), .Reset(rst), .bus(b_if.slave)
  );

  assign a_if.ID_Rs = id_rs;        assign b_if.ID_Rs = id_rs;
  assign a_if.ID_Rt = id_rt;        assign b_if.ID_Rt = id_rt;
  assign a_if.ID_UsesRs = id_uses_rs; assign b_if.ID_UsesRs = id_uses_rs;
  assign a_if.ID_UsesRt = id_uses_rt; assign b_if.ID_UsesRt = id_uses_rt;
  assign a_if.ID_Jump = id_jump;    assign b_if.ID_Jump = id_jump;
  assign a_if.EX_Rs = ex_rs;        assign b_if.EX_Rs = ex_rs;
  assign a_if.EX_Rt = ex_rt;        assign b_if.EX_Rt = ex_rt;
  assign a_if.EX_MemRead = ex_memread; assign b_if.EX_MemRead = ex_memread;
  assign a_if.EX_WriteReg = ex_wr;  assign b_if.EX_WriteReg = ex_wr;
  assign a_if.EX_Jr = ex_jr;        assign b_if.EX_Jr = ex_jr;
  assign a_if.M_RegWrite = m_regwrite; assign b_if.M_RegWrite = m_regwrite;
  assign a_if.M_WriteReg = m_wr;    assign b_if.M_WriteReg = m_wr;
  assign a_if.M_PCSrc = m_pcsrc;    assign b_if.M_PCSrc = m_pcsrc;
  assign a_if.WB_RegWrite = wb_regwrite; assign b_if.WB_RegWrite = wb_regwrite;
  assign a_if.WB_WriteReg = wb_wr;  assign b_if.WB_WriteReg = wb_wr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_wr = '0; m_wr = '0; wb_wr = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0; ex_memread = 1'b0; ex_jr = 1'b0;
    m_regwrite = 1'b0; m_pcsrc = 1'b0; wb_regwrite = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // lw $2 in EX, add $3,$2,$4 in ID
  task automatic set_load_use();
    ex_memread = 1'b1; ex_wr = 5'd2;
    id_rs = 5'd2; id_uses_rs = 1'b1; id_rt = 5'd4; id_uses_rt = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    ex_rs = 5'd5; m_regwrite = 1'b1; m_wr = 5'd5; m_pcsrc = 1'b0;
    tick();
    #1;
    check_eq("rst_pcwrite",  a_if.PCWrite, 0);
    check_eq("rst_ifidw",    a_if.IFID_Write, 0);
    check_eq("rst_flushes",  {a_if.IFID_Flush, a_if.IDEX_Flush, a_if.EXMEM_Flush}, 3'b111);
    check_eq("rst_fwda",     a_if.ForwardA, 2'b00);
    check_eq("rst_stallcnt", b_if.StallCount, 0);
    check_eq("rst_flushcnt", b_if.FlushCount, 0);

    // Idle run after reset
    do_reset();
    #1;
    check_eq("run_pcwrite", b_if.PCWrite, 1);
    check_eq("run_ifidw",   b_if.IFID_Write, 1);
    check_eq("run_flushes", {b_if.IFID_Flush, b_if.IDEX_Flush, b_if.EXMEM_Flush}, 3'b000);

    // Load-use: one bubble on a, three on b
    do_reset();
    set_load_use();
    #1;
    check_eq("lu_a_pcwrite", a_if.PCWrite, 0);
    check_eq("lu_a_ifidw",   a_if.IFID_Write, 0);
    check_eq("lu_a_idexfl",  a_if.IDEX_Flush, 1);
    check_eq("lu_b_pcwrite", b_if.PCWrite, 0);
    tick();
    clear_inputs();
    #1;
    check_eq("lu_a_resume",   a_if.PCWrite, 1);
    check_eq("lu_a_stallcnt", a_if.StallCount, 1);
    check_eq("lu_b_stall2",   b_if.PCWrite, 0);
    tick();
    #1;
    check_eq("lu_b_stall3",   b_if.PCWrite, 0);
    check_eq("lu_b_idexfl3",  b_if.IDEX_Flush, 1);
    tick();
    #1;
    check_eq("lu_b_resume",   b_if.PCWrite, 1);
    check_eq("lu_b_stallcnt", b_if.StallCount, 3);
    check_eq("lu_b_flushcnt", b_if.FlushCount, 3);
    check_eq("lu_a_stallcnt2", a_if.StallCount, 1);

    // Branch taken in stall cycle 2 of 3
    do_reset();
    set_load_use();
    tick();
    clear_inputs();
    m_pcsrc = 1'b1;
    #1;
    check_eq("br_b_flushes", {b_if.IFID_Flush, b_if.IDEX_Flush, b_if.EXMEM_Flush}, 3'b111);
    check_eq("br_b_pcwrite", b_if.PCWrite, 1);
    tick();
    m_pcsrc = 1'b0;
    #1;
    check_eq("br_b_run",      b_if.PCWrite, 1);
    check_eq("br_b_stallcnt", b_if.StallCount, 1);
    check_eq("br_b_flushcnt", b_if.FlushCount, 2);

    // jr together with j: jr wins, EX/MEM untouched
    do_reset();
    ex_jr = 1'b1; id_jump = 1'b1;
    #1;
    check_eq("jr_flushes", {a_if.IFID_Flush, a_if.IDEX_Flush, a_if.EXMEM_Flush}, 3'b110);
    check_eq("jr_pcwrite", a_if.PCWrite, 1);
    tick();
    ex_jr = 1'b0;
    #1;
    check_eq("jr_flushcnt", a_if.FlushCount, 1);
    check_eq("j_flushes",   {a_if.IFID_Flush, a_if.IDEX_Flush, a_if.EXMEM_Flush}, 3'b100);
    check_eq("j_pcwrite",   a_if.PCWrite, 1);
    set_load_use();
    #1;
    check_eq("j_lu_flushes", {a_if.IFID_Flush, a_if.IDEX_Flush, a_if.EXMEM_Flush}, 3'b010);
    check_eq("j_lu_pcwrite", a_if.PCWrite, 0);
    clear_inputs();
    ex_memread = 1'b1; ex_wr = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    #1;
    check_eq("lu_r0_pcwrite", a_if.PCWrite, 1);

    // Forwarding
    clear_inputs();
    ex_rs = 5'd5; m_regwrite = 1'b1; m_wr = 5'd5; wb_regwrite = 1'b1; wb_wr = 5'd5;
    #1;
    check_eq("fwd_mem_beats_wb", a_if.ForwardA, 2'b10);
    ex_rs = 5'd0; m_wr = 5'd0; wb_wr = 5'd0;
    #1;
    check_eq("fwd_r0", a_if.ForwardA, 2'b00);
    ex_rt = 5'd7; m_wr = 5'd5; wb_wr = 5'd7;
    #1;
    check_eq("fwd_b_wb", b_if.ForwardB, 2'b01);
    ex_rt = 5'd5; m_regwrite = 1'b0; wb_wr = 5'd5;
    #1;
    check_eq("fwd_b_mem_off", b_if.ForwardB, 2'b01);
    wb_regwrite = 1'b0;
    #1;
    check_eq("fwd_b_none", b_if.ForwardB, 2'b00);

    // Reset pulsed mid-stall
    do_reset();
    set_load_use();
    tick();
    clear_inputs();
    rst = 1'b1;
    #1;
    check_eq("rst_mid_pcwrite", b_if.PCWrite, 0);
    check_eq("rst_mid_exmemfl", b_if.EXMEM_Flush, 1);
    tick();
    rst = 1'b0;
    #1;
    check_eq("rst_mid_run",      b_if.PCWrite, 1);
    check_eq("rst_mid_stallcnt", b_if.StallCount, 0);
    check_eq("rst_mid_flushcnt", b_if.FlushCount, 0);

    // Held hazard: a saturates its 4-bit counter, b keeps re-arming
    do_reset();
    set_load_use();
    for (int unsigned i = 0; i < 20; i++) tick();
    clear_inputs();
    #1;
    check_eq("sat_a_stallcnt", a_if.StallCount, 15);
    check_eq("sat_a_flushcnt", a_if.FlushCount, 15);
    check_eq("rearm_b_stallcnt", b_if.StallCount, 20);
    check_eq("rearm_b_still", b_if.PCWrite, 0);
    tick();
    #1;
    check_eq("rearm_b_resume", b_if.PCWrite, 1);
    check_eq("sat_a_hold",     a_if.StallCount, 15);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
